// File: rtl/store_buffer_pkg.sv
// Shared MIPS constants and the pending-store entry payload used by the store buffer.
package store_buffer_pkg;

  localparam int unsigned WORD_W       = 32;
  localparam int unsigned IDX_BITS_DEF = 8;

  typedef struct packed {
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer.sv
// FIFO store buffer between the CPU and data memory: drains stores when the port is free,
// forwards loads from the youngest matching pending store, stalls only on a full buffer.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned IDX_BITS = IDX_BITS_DEF,
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] address,
  input  logic [WORD_W-1:0] write_data,
  input  logic              memwrite,
  input  logic              memread,
  output logic [WORD_W-1:0] read_data,
  output logic              stall,
  output logic              empty,
  output logic [CNT_W-1:0]  count,
  output logic [WORD_W-1:0] mem_address,
  output logic [WORD_W-1:0] mem_write_data,
  output logic              mem_memwrite,
  output logic              mem_memread,
  input  logic [WORD_W-1:0] mem_read_data
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  sb_entry_t          entry_q [DEPTH];
  logic [DEPTH-1:0]   valid_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [CNT_W-1:0]   count_q;

  sb_entry_t          head;
  logic               full;
  logic               drain;
  logic               push;
  logic               hit;
  logic [WORD_W-1:0]  fwd_data;

  assign head  = entry_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  // A load owns the memory port, so draining only happens on cycles without one.
  assign drain = ~empty & ~memread;
  assign stall = memwrite & full & ~drain;
  assign push  = memwrite & ~stall;
  assign count = count_q;

  // Walk oldest to youngest so the last match seen is the youngest store.
  always_comb begin : fwd_search
    logic [PTR_W-1:0] slot;
    hit      = 1'b0;
    fwd_data = '0;
    slot     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = rd_ptr_q + PTR_W'(k);
      if (valid_q[slot] &&
          (entry_q[slot].addr[IDX_BITS-1:0] == address[IDX_BITS-1:0])) begin
        hit      = 1'b1;
        fwd_data = entry_q[slot].data;
      end
    end
  end

  assign read_data      = memread ? (hit ? fwd_data : mem_read_data) : {WORD_W{1'bz}};
  assign mem_memread    = memread & ~hit;
  assign mem_memwrite   = drain;
  assign mem_address    = memread ? address : (drain ? head.addr : '0);
  assign mem_write_data = drain ? head.data : '0;

  // Pop is applied before push so a full buffer can drain and refill the same slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      if (drain) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= rd_ptr_q + PTR_W'(1);
      end
      if (push) begin
        entry_q[wr_ptr_q] <= '{addr: address, data: write_data};
        valid_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
      end
      case ({push, drain})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed vector table, then random traffic vs a queue model.
module tb_store_buffer;
  import store_buffer_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam logic T = 1'b1;
  localparam logic F = 1'b0;

  logic        clk;
  logic        rst_n;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        memwrite;
  logic        memread;
  logic [31:0] read_data;
  logic        stall;
  logic        empty;
  logic [2:0]  count;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_memwrite;
  logic        mem_memread;
  logic [31:0] mem_read_data;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .address       (address),
    .write_data    (write_data),
    .memwrite      (memwrite),
    .memread       (memread),
    .read_data     (read_data),
    .stall         (stall),
    .empty         (empty),
    .count         (count),
    .mem_address   (mem_address),
    .mem_write_data(mem_write_data),
    .mem_memwrite  (mem_memwrite),
    .mem_memread   (mem_memread),
    .mem_read_data (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        rst;
    logic        mw;
    logic        mr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] mrd;
    logic        e_stall;
    logic        e_empty;
    logic [2:0]  e_count;
    logic        e_mmw;
    logic        e_mmr;
    logic [31:0] e_maddr;
    logic [31:0] e_mwd;
    logic [31:0] e_rd;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } ent_t;

  vec_t vecs[$];
  ent_t model_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic mw, input logic mr,
                     input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] mrd,
                     input logic es, input logic ee, input logic [2:0] ec,
                     input logic emw, input logic emr,
                     input logic [31:0] ema, input logic [31:0] emd, input logic [31:0] erd);
    vec_t v;
    v = '{rst, mw, mr, addr, wd, mrd, es, ee, ec, emw, emr, ema, emd, erd};
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rst, input logic mw, input logic mr,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] mrd);
    rst_n         = rst;
    memwrite      = mw;
    memread       = mr;
    address       = addr;
    write_data    = wd;
    mem_read_data = mrd;
  endtask

  task automatic check_all(input string tag, input logic mr, input logic es, input logic ee,
                           input logic [2:0] ec, input logic emw, input logic emr,
                           input logic [31:0] ema, input logic [31:0] emd, input logic [31:0] erd);
    chk({tag, ".stall"},        32'(stall),        32'(es));
    chk({tag, ".empty"},        32'(empty),        32'(ee));
    chk({tag, ".count"},        32'(count),        32'(ec));
    chk({tag, ".mem_memwrite"}, 32'(mem_memwrite), 32'(emw));
    chk({tag, ".mem_memread"},  32'(mem_memread),  32'(emr));
    if (emw || emr) chk({tag, ".mem_address"}, mem_address, ema);
    if (emw)        chk({tag, ".mem_write_data"}, mem_write_data, emd);
    if (mr)         chk({tag, ".read_data"}, read_data, erd);
  endtask

  initial begin
    // Directed scenarios: store/drain, youngest forward, stall on full, miss, alias, reset mid-drain.
    add(T,T,F,32'h10,32'hDEADBEEF,0,          F,T,3'd0,F,F,0,0,0);
    add(T,F,F,0,0,0,                          F,F,3'd1,T,F,32'h10,32'hDEADBEEF,0);
    add(T,F,F,0,0,0,                          F,T,3'd0,F,F,0,0,0);
    add(T,T,T,32'h20,32'h1,32'h55,            F,T,3'd0,F,T,32'h20,0,32'h55);
    add(T,T,T,32'h20,32'h2,32'h66,            F,F,3'd1,F,F,0,0,32'h1);
    add(T,F,T,32'h20,0,32'h77,                F,F,3'd2,F,F,0,0,32'h2);
    add(T,T,T,32'h30,32'h3,32'h88,            F,F,3'd2,F,T,32'h30,0,32'h88);
    add(T,T,T,32'h34,32'h4,32'h0,             F,F,3'd3,F,T,32'h34,0,32'h0);
    add(T,T,T,32'h38,32'h5,32'h99,            T,F,3'd4,F,T,32'h38,0,32'h99);
    add(T,T,F,32'h38,32'h5,0,                 F,F,3'd4,T,F,32'h20,32'h1,0);
    add(T,F,T,32'h38,0,0,                     F,F,3'd4,F,F,0,0,32'h5);
    add(T,F,T,32'h20,0,0,                     F,F,3'd4,F,F,0,0,32'h2);
    add(T,F,F,0,0,0,                          F,F,3'd4,T,F,32'h20,32'h2,0);
    add(T,F,F,0,0,0,                          F,F,3'd3,T,F,32'h30,32'h3,0);
    add(T,F,F,0,0,0,                          F,F,3'd2,T,F,32'h34,32'h4,0);
    add(T,F,F,0,0,0,                          F,F,3'd1,T,F,32'h38,32'h5,0);
    add(T,F,F,0,0,0,                          F,T,3'd0,F,F,0,0,0);
    add(T,F,T,32'h44,0,32'hCAFE0000,          F,T,3'd0,F,T,32'h44,0,32'hCAFE0000);
    add(T,T,F,32'h105,32'hA5A5,0,             F,T,3'd0,F,F,0,0,0);
    add(T,F,T,32'h005,0,32'h1234,             F,F,3'd1,F,F,0,0,32'hA5A5);
    add(T,F,F,0,0,0,                          F,F,3'd1,T,F,32'h105,32'hA5A5,0);
    add(T,F,F,0,0,0,                          F,T,3'd0,F,F,0,0,0);
    add(T,T,T,32'h50,32'h11,0,                F,T,3'd0,F,T,32'h50,0,0);
    add(T,T,T,32'h54,32'h22,0,                F,F,3'd1,F,T,32'h54,0,0);
    add(T,T,T,32'h58,32'h33,0,                F,F,3'd2,F,T,32'h58,0,0);
    add(F,F,F,0,0,0,                          F,F,3'd3,T,F,32'h50,32'h11,0);
    add(T,F,F,0,0,0,                          F,T,3'd0,F,F,0,0,0);
    add(T,F,T,32'h54,0,32'hBEEF,              F,T,3'd0,F,T,32'h54,0,32'hBEEF);
    add(T,F,F,0,0,0,                          F,T,3'd0,F,F,0,0,0);

    drive(F, F, F, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    drive(T, F, F, 0, 0, 0);
    #2;
    check_all("reset", F, F, T, 3'd0, F, F, 0, 0, 0);
    drive(T, F, T, 32'h0ABC, 0, 32'h7777);
    #1;
    check_all("reset_load", T, F, T, 3'd0, F, T, 32'h0ABC, 0, 32'h7777);
    drive(T, F, F, 0, 0, 0);
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].mw, vecs[i].mr, vecs[i].addr, vecs[i].wd, vecs[i].mrd);
      #2;
      check_all($sformatf("v%0d", i), vecs[i].mr, vecs[i].e_stall, vecs[i].e_empty,
                vecs[i].e_count, vecs[i].e_mmw, vecs[i].e_mmr, vecs[i].e_maddr,
                vecs[i].e_mwd, vecs[i].e_rd);
      @(posedge clk);
      #1;
    end

    // Random traffic against a FIFO queue model; buffer is empty here after the last vector.
    for (int n = 0; n < 400; n++) begin
      logic        r_rst, r_mw, r_mr, hit, full, drn, stl;
      logic [31:0] r_addr, r_wd, r_mrd, tmp, e_rd, e_maddr, e_mwd;
      int          sz;
      r_rst  = ($urandom_range(0, 49) != 0);
      r_mw   = ($urandom_range(0, 9) < 6);
      r_mr   = ($urandom_range(0, 9) < 4);
      tmp    = $urandom();
      r_addr = (tmp & 32'hFFFF_FF00) | 32'($urandom_range(0, 5));
      r_wd   = $urandom();
      r_mrd  = $urandom();

      sz   = model_q.size();
      full = (sz == DEPTH);
      drn  = (sz != 0) && !r_mr;
      stl  = r_mw && full && !drn;
      hit  = 1'b0;
      e_rd = r_mrd;
      for (int j = sz - 1; j >= 0; j--) begin
        if (!hit && (model_q[j].addr[7:0] == r_addr[7:0])) begin
          hit  = 1'b1;
          e_rd = model_q[j].data;
        end
      end
      e_maddr = r_mr ? r_addr : ((sz != 0) ? model_q[0].addr : 32'h0);
      e_mwd   = (sz != 0) ? model_q[0].data : 32'h0;

      drive(r_rst, r_mw, r_mr, r_addr, r_wd, r_mrd);
      #2;
      check_all($sformatf("rnd%0d", n), r_mr, stl, (sz == 0), 3'(sz), drn,
                r_mr && !hit, e_maddr, e_mwd, e_rd);

      if (!r_rst) begin
        model_q.delete();
      end else begin
        if (drn) void'(model_q.pop_front());
        if (r_mw && !stl) model_q.push_back('{r_addr, r_wd});
      end
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: STORE_BUFFER

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of pending-store entries (power of 2, >=2).
REQ-002 SHALL have parameter IDX_BITS, default 8, low address bits used as the data-memory word index.
REQ-003 SHALL have ports, listed below, with clock and reset first.
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- address  input  32  CPU load/store address.
- write_data  input  32  CPU store data.
- memwrite  input  1  CPU store request.
- memread  input  1  CPU load request.
- read_data  output  32  load result.
- stall  output  1  store not accepted this cycle; pipeline must hold.
- empty  output  1  no pending stores.
- count  output  clog2(DEPTH+1)  current occupancy.
- mem_address  output  32  to data memory.
- mem_write_data  output  32  to data memory.
- mem_memwrite  output  1  to data memory.
- mem_memread  output  1  to data memory.
- mem_read_data  input  32  from data memory.

Function
REQ-004 SHALL hold up to DEPTH {address, data} entries in FIFO order (head = oldest).
REQ-005 SHALL enqueue {address, write_data} at the clock edge when memwrite=1 and stall=0.
REQ-006 SHALL compute stall combinationally: stall = memwrite & full & ~drain, where drain is defined in REQ-007.
REQ-007 SHALL drain when ~empty & ~memread: drive mem_memwrite=1, mem_address=head address, mem_write_data=head data; pop head at the edge.
REQ-008 SHALL let a load own the memory port: when memread=1, mem_memwrite=0 and no drain occurs that cycle.
REQ-009 SHALL, on memread=1, compare address[IDX_BITS-1:0] against all valid entries.
- On a hit, read_data = data of the youngest matching entry; mem_memread=0.
- On a miss, mem_memread=1, mem_address=address, read_data=mem_read_data.
- Single-cycle combinational latency in both cases.
REQ-010 SHALL drive read_data=32'bz when memread=0.
REQ-011 SHALL handle full with drain in the same cycle: pop and push both occur, count unchanged, stall=0.
REQ-012 SHALL handle memread=1 & memwrite=1 together: the load is forwarded from pre-enqueue contents; the store follows REQ-005/006.
REQ-013 SHALL drive mem_memread=0 and mem_memwrite=0 when idle (no load, empty).
REQ-014 SHALL wrap read/write pointers modulo DEPTH; count increments on push only, decrements on pop only.
REQ-015 SHALL assert empty exactly when count=0; full exactly when count=DEPTH.

Reset
REQ-016 SHALL, on rst_n=0 at an edge, set pointers=0, count=0, all valid bits=0, entry data=0.
REQ-017 SHALL discard in-flight stores when reset is asserted mid-drain; no further mem_memwrite after reset.
REQ-018 SHALL present outputs after reset as: stall=0, empty=1, count=0, mem_memwrite=0, mem_memread=memread, read_data per REQ-009/010.

Structure
REQ-019 SHALL take IDX_BITS default and word width 32 from the shared MIPS constants header; DEPTH stays local.
REQ-020 SHALL be a single module; the youngest-match priority search is inline with no sub-module.

Verification
REQ-021 SHALL cover store then drain.
- Stimulus: store addr 0x10 data 0xDEADBEEF, then idle.
- Response: next cycle mem_memwrite=1, mem_address=0x10; empty=1 after the edge.
REQ-022 SHALL cover forwarding of the youngest match.
- Stimulus: 2 stores to 0x20 (0x1, then 0x2) while loads hold the port, then load 0x20.
- Response: read_data=0x2, mem_memread=0.
REQ-023 SHALL cover stall on full.
- Stimulus: 4 stores back-to-back under continuous memread, then a 5th store with memread=1.
- Response: stall=1, count stays 4.
- Stimulus: drop memread.
- Response: stall=0, 5th entry accepted, count=4.
REQ-024 SHALL cover a miss pass-through.
- Stimulus: load 0x44 with buffer empty, mem_read_data=0xCAFE0000.
- Response: mem_memread=1, read_data=0xCAFE0000.
REQ-025 SHALL cover aliasing.
- Stimulus: store 0x105, then load 0x005 before drain.
- Response: hit, read_data = stored data.
REQ-026 SHALL cover reset mid-drain.
- Stimulus: 3 pending stores, rst_n=0 for 1 cycle.
- Response: count=0, empty=1, no mem_memwrite afterwards.
